// File: rtl/alu_seq16.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq16
//  Brief    : Sequences a 2N-bit ADD/AND/OR/XOR through an external N-bit ALU
//             in two halves (low then high), assembling the wide result and
//             its carry/zero flags behind a valid/ready request/response pair.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq16 #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   // request channel
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [2*N-1:0] req_a,
   input  logic [2*N-1:0] req_b,
   // response channel
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [2*N-1:0] resp_data,
   output logic           resp_carry,
   output logic           resp_zero,
   // external ALU command side
   output logic           alu_enable,
   output logic [2:0]     alu_mode,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   // external ALU result side (registered one clock after an enabled edge)
   input  logic [N-1:0]   alu_out,
   input  logic           alu_flag_zero,
   input  logic           alu_flag_carry
);

   // ALU mode encodings shared with the external ALU; 0 means no operation
   localparam logic [2:0] c_ALU_NOP = 3'd0;
   localparam logic [2:0] c_ALU_ADD = 3'd1;
   localparam logic [2:0] c_ALU_ADC = 3'd2;
   localparam logic [2:0] c_ALU_AND = 3'd3;
   localparam logic [2:0] c_ALU_OR  = 3'd4;
   localparam logic [2:0] c_ALU_XOR = 3'd5;

   // request opcodes
   localparam logic [1:0] c_OP_ADD = 2'd0;
   localparam logic [1:0] c_OP_AND = 2'd1;
   localparam logic [1:0] c_OP_OR  = 2'd2;
   localparam logic [1:0] c_OP_XOR = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t         r_state;
   logic [1:0]     r_op;        // opcode of the operation in flight
   logic [N-1:0]   r_a_hi;      // high operand halves, held until the HI step
   logic [N-1:0]   r_b_hi;
   logic [N-1:0]   r_res_lo;    // low result half captured leaving HI
   logic           r_lo_zero;   // zero flag of the low result half

   // Low half always uses a plain ADD so a stale carry left in the ALU
   // (e.g. after an abandoned operation) can never leak into a new sum.
   function automatic logic [2:0] lo_mode(input logic [1:0] op);
      logic [2:0] m;
      case (op)
         c_OP_ADD: m = c_ALU_ADD;
         c_OP_AND: m = c_ALU_AND;
         c_OP_OR:  m = c_ALU_OR;
         default:  m = c_ALU_XOR;
      endcase
      return m;
   endfunction

   // High half chains the carry from the low ADD; logic ops repeat their mode.
   function automatic logic [2:0] hi_mode(input logic [1:0] op);
      logic [2:0] m;
      if (op == c_OP_ADD) begin
         m = c_ALU_ADC;
      end else begin
         m = lo_mode(op);
      end
      return m;
   endfunction

   // Sequencer: state, ALU command and response are all registered here so
   // every output is glitch-free and cleared together by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= c_OP_ADD;
         r_a_hi     <= '0;
         r_b_hi     <= '0;
         r_res_lo   <= '0;
         r_lo_zero  <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_carry <= 1'b0;
         resp_zero  <= 1'b0;
         alu_enable <= 1'b0;
         alu_mode   <= c_ALU_NOP;
         alu_a      <= '0;
         alu_b      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  // Latch everything needed later; the low halves go
                  // straight onto the ALU command for the LO cycle.
                  r_op       <= req_op;
                  r_a_hi     <= req_a[2*N-1:N];
                  r_b_hi     <= req_b[2*N-1:N];
                  req_ready  <= 1'b0;
                  alu_enable <= 1'b1;
                  alu_mode   <= lo_mode(req_op);
                  alu_a      <= req_a[N-1:0];
                  alu_b      <= req_b[N-1:0];
                  r_state    <= S_LO;
               end
            end

            S_LO: begin
               // Issue the high half immediately after the low one so the
               // ALU carry from the low ADD is still intact for the ADC.
               alu_mode <= hi_mode(r_op);
               alu_a    <= r_a_hi;
               alu_b    <= r_b_hi;
               r_state  <= S_HI;
            end

            S_HI: begin
               // alu_out now holds the low-half result.
               r_res_lo   <= alu_out;
               r_lo_zero  <= alu_flag_zero;
               alu_enable <= 1'b0;
               alu_mode   <= c_ALU_NOP;
               alu_a      <= '0;
               alu_b      <= '0;
               r_state    <= S_WB;
            end

            S_WB: begin
               // alu_out now holds the high-half result and final flags.
               resp_data  <= {alu_out, r_res_lo};
               resp_zero  <= r_lo_zero & alu_flag_zero;
               resp_carry <= (r_op == c_OP_ADD) ? alu_flag_carry : 1'b0;
               resp_valid <= 1'b1;
               r_state    <= S_DONE;
            end

            S_DONE: begin
               // Response fields stay untouched until the consumer takes them.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               alu_enable <= 1'b0;
               alu_mode   <= c_ALU_NOP;
               alu_a      <= '0;
               alu_b      <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the ALU datapath width in bits; operands and result SHALL be 2N bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_op, input, 2 bits: 0=ADD16, 1=AND16, 2=OR16, 3=XOR16.
REQ-007 The block SHALL have ports req_a and req_b, input, 2N bits each: the operands.
REQ-008 The block SHALL have port resp_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have ports resp_data (output, 2N bits), resp_carry (output, 1 bit) and resp_zero (output, 1 bit): the result and its flags.
REQ-011 The block SHALL have ports alu_enable (output, 1 bit), alu_mode (output, 3 bits), alu_a (output, N bits) and alu_b (output, N bits): these drive the ALU.
REQ-012 The block SHALL have ports alu_out (input, N bits), alu_flag_zero (input, 1 bit) and alu_flag_carry (input, 1 bit): these come from the ALU, which registers its result one clock after an enabled edge.

Function
REQ-013 States: IDLE, LO, HI, WB, DONE; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on an edge with req_valid=1, latch req_op/req_a/req_b and go to LO; otherwise stay in IDLE.
REQ-015 LO: alu_enable=1, alu_a/alu_b = low N bits of latched operands; alu_mode = ALU_ADD for ADD16, else ALU_AND/ALU_OR/ALU_XOR per op (shared parameter macros); next state HI.
REQ-016 HI: alu_enable=1, alu_a/alu_b = high N bits; alu_mode = ALU_ADC for ADD16, else same logic mode as LO; on the exiting edge capture alu_out as low result byte and alu_flag_zero as low-zero; next state WB.
REQ-017 The ADC in HI SHALL rely on the ALU carry produced by the LO ADD; no other ALU operation may be issued between LO and HI.
REQ-018 WB: alu_enable=0; on the exiting edge capture alu_out as high result byte; next state DONE.
REQ-019 resp_zero SHALL equal low-zero AND alu_flag_zero sampled at the WB exit edge; resp_carry SHALL equal alu_flag_carry at that edge for ADD16, and 0 for logic ops.
REQ-020 DONE: resp_data/resp_carry/resp_zero SHALL be held stable while resp_valid=1 and resp_ready=0; an edge with resp_ready=1 SHALL return to IDLE.
REQ-021 Latency: resp_valid SHALL rise exactly 3 clocks after the accepting edge; throughput is at most one request per 5 clocks (no accept in DONE).
REQ-022 Outside LO/HI, alu_enable SHALL be 0, and alu_mode/alu_a/alu_b SHALL be 0.
REQ-023 req_a/req_b/req_op changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_carry=0, resp_zero=0, alu_enable=0, alu_mode=0, alu_a=0, alu_b=0, regardless of clock.
REQ-025 Reset mid-operation SHALL abandon the operation with no response; the next ADD16 SHALL be correct despite stale ALU carry, because LO always issues ADD, never ADC.
REQ-026 Leaving reset, the first request SHALL be accepted on the first rising edge with rst_n=1 and req_valid=1.

Verification
REQ-027 ADD16 0x12FF+0x0001 -> alu_mode ALU_ADD then ALU_ADC; resp_data=0x1300, carry=0, zero=0, 3 clocks after accept.
REQ-028 ADD16 0xFFFF+0x0001 -> resp_data=0x0000, carry=1, zero=1; ADD16 0x0100+0x0000 -> 0x0100, zero=0 (low byte zero only).
REQ-029 AND16 0xF0F0&0x0F0F -> 0x0000, zero=1, carry=0; XOR16 0xAAAA^0x5555 -> 0xFFFF, zero=0, carry=0.
REQ-030 resp_ready held 0 for 5 clocks with req_valid=1 and new operands -> resp fields unchanged, req_ready=0, second request accepted only after the DONE handshake.
REQ-031 rst_n pulsed low while in HI -> all outputs at reset values asynchronously, no response; then ADD16 0x0001+0x0001 -> 0x0002, carry=0.
REQ-032 resp_ready and req_valid held 1 continuously -> one accept every 5 clocks, each result correct.
